// File: rtl/haz_pkg.sv
// haz_pkg: shared forward-select, Tuse and Tnew encodings for the D-stage hazard unit.
package haz_pkg;
    localparam logic [1:0] FWD_RF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2, FWD_W = 2'd3;
    localparam logic [1:0] TUSE_BR = 2'd0, TUSE_ALU = 2'd1, TUSE_ST = 2'd2;
    localparam logic [1:0] TNEW_PC8 = 2'd0, TNEW_ALU = 2'd1, TNEW_LD = 2'd2;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/hazard_md_timer.sv
// hazard_md_timer: HI/LO occupancy counter, loaded on mult/div issue and counted down to idle.
module hazard_md_timer
    import haz_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam int CW = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (start) cnt <= div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign busy = cnt != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register Tnew/age scoreboard producing D-stage stall and forward selects.
// Define HAZ_MD_EN to add the mult/div HI/LO busy interlock.
module hazard_scoreboard
    import haz_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int TW         = 2,
    parameter int DEPTH      = 3,
    parameter int MD_MUL_LAT = 5,
    parameter int MD_DIV_LAT = 10,
    localparam int AW        = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_rs_use,
    input  logic          d_rt_use,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic          d_wr_en,
    input  logic [AW-1:0] d_wr_addr,
    input  logic [TW-1:0] d_wr_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel,
    output logic          md_busy
);
    if (DEPTH < 1 || DEPTH > 3) begin : g_bad_depth
        $error("hazard_scoreboard: DEPTH must be 1..3 to fit the 2-bit age field");
    end
    logic [NREG-1:0]         pend_v;
    logic [NREG-1:0][TW-1:0] cnt_v;
    logic [NREG-1:0][1:0]    age_v;
    logic issue, rs_haz, rt_haz, md_haz;
    assign issue = d_valid & ~stall;
    assign pend_v[0] = 1'b0;
    assign cnt_v[0]  = '0;
    assign age_v[0]  = '0;
    genvar r;
    for (r = 1; r < NREG; r++) begin : g_ent
        logic          p, ld;
        logic [TW-1:0] c;
        logic [1:0]    a;
        assign ld = issue & d_wr_en & (d_wr_addr == AW'(r));
        // a fresh load always beats aging so the youngest producer owns the entry
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                p <= 1'b0;
                c <= '0;
                a <= '0;
            end else if (ld) begin
                p <= 1'b1;
                c <= d_wr_tnew;
                a <= 2'd1;
            end else if (p && a == 2'(DEPTH)) begin
                p <= 1'b0;
                c <= '0;
                a <= '0;
            end else if (p) begin
                c <= c == '0 ? '0 : c - 1'b1;
                a <= a + 2'd1;
            end
        assign pend_v[r] = p;
        assign cnt_v[r]  = c;
        assign age_v[r]  = a;
    end
    assign rs_haz = d_rs_use & (d_rs != '0) & pend_v[d_rs] & (cnt_v[d_rs] > d_rs_tuse);
    assign rt_haz = d_rt_use & (d_rt != '0) & pend_v[d_rt] & (cnt_v[d_rt] > d_rt_tuse);
    assign stall = d_valid & (rs_haz | rt_haz | md_haz);
    assign fwd_rs_sel = pend_v[d_rs] ? age_v[d_rs] : FWD_RF;
    assign fwd_rt_sel = pend_v[d_rt] ? age_v[d_rt] : FWD_RF;
`ifdef HAZ_MD_EN
    hazard_md_timer #(.MUL_LAT(MD_MUL_LAT), .DIV_LAT(MD_DIV_LAT)) u_md (
        .clk(clk),
        .reset(reset),
        .start(issue & d_md_start),
        .div(d_md_div),
        .busy(md_busy)
    );
    assign md_haz = d_md_use & md_busy;
`else
    localparam int unused_md_lat = MD_MUL_LAT + MD_DIV_LAT;
    logic unused_md;
    assign unused_md = d_md_start ^ d_md_div ^ d_md_use;
    assign md_busy = 1'b0;
    assign md_haz  = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus hand-written mult/div and async-reset sequences.
module tb_hazard_scoreboard;
    import haz_pkg::*;
`ifdef HAZ_MD_EN
    localparam logic MD = 1'b1;
`else
    localparam logic MD = 1'b0;
`endif
    logic clk, reset, d_valid, d_rs_use, d_rt_use, d_wr_en, d_md_start, d_md_div, d_md_use;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_wr_tnew, fwd_rs_sel, fwd_rt_sel;
    logic stall, md_busy;
    int passed = 0, total = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_wr_tnew(d_wr_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [4:0] rs;
        logic       rsu;
        logic [1:0] rst;
        logic [4:0] rt;
        logic       rtu;
        logic [1:0] rtt;
        logic       we;
        logic [4:0] wa;
        logic [1:0] tn;
        logic       e_stall;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic vld, input logic [4:0] rs, input logic rsu, input logic [1:0] rst,
                                input logic [4:0] rt, input logic rtu, input logic [1:0] rtt,
                                input logic we, input logic [4:0] wa, input logic [1:0] tn,
                                input logic es, input logic [1:0] ers, input logic [1:0] ert);
        vec_t v;
        v.vld = vld; v.rs = rs; v.rsu = rsu; v.rst = rst; v.rt = rt; v.rtu = rtu; v.rtt = rtt;
        v.we = we; v.wa = wa; v.tn = tn; v.e_stall = es; v.e_rs = ers; v.e_rt = ert;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        d_valid = v.vld; d_rs = v.rs; d_rs_use = v.rsu; d_rs_tuse = v.rst;
        d_rt = v.rt; d_rt_use = v.rtu; d_rt_tuse = v.rtt;
        d_wr_en = v.we; d_wr_addr = v.wa; d_wr_tnew = v.tn;
        d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    endtask

    task automatic chk(input string name, input logic es, input logic [1:0] ers, input logic [1:0] ert, input logic eb);
        total++;
        if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== {es, ers, ert, eb})
            $display("FAIL %s: got stall=%b rs=%0d rt=%0d busy=%b, expected stall=%b rs=%0d rt=%0d busy=%b",
                     name, stall, fwd_rs_sel, fwd_rt_sel, md_busy, es, ers, ert, eb);
        else passed++;
    endtask

    initial begin
        //            vld rs rsu rst  rt rtu rtt  we wa tn   stall rs rt
        vecs[0]  = mk(1, 29, 1, TUSE_ALU, 0, 0, 0, 1, 1, TNEW_LD,  0, FWD_RF, FWD_RF);
        vecs[1]  = mk(1, 1,  1, TUSE_ALU, 3, 1, 1, 1, 2, TNEW_ALU, 1, FWD_E,  FWD_RF);
        vecs[2]  = mk(1, 1,  1, TUSE_ALU, 3, 1, 1, 1, 2, TNEW_ALU, 0, FWD_M,  FWD_RF);
        vecs[3]  = mk(1, 3,  1, TUSE_ALU, 7, 1, 1, 1, 6, TNEW_ALU, 0, FWD_RF, FWD_RF);
        vecs[4]  = mk(1, 6,  1, TUSE_BR,  0, 1, 0, 0, 0, 0,        1, FWD_E,  FWD_RF);
        vecs[5]  = mk(1, 6,  1, TUSE_BR,  0, 1, 0, 0, 0, 0,        0, FWD_M,  FWD_RF);
        vecs[6]  = mk(1, 29, 1, TUSE_ALU, 0, 0, 0, 1, 5, TNEW_LD,  0, FWD_RF, FWD_RF);
        vecs[7]  = mk(1, 0,  1, TUSE_ALU, 5, 1, TUSE_ST, 0, 0, 0,  0, FWD_RF, FWD_E);
        vecs[8]  = mk(1, 5,  1, TUSE_ALU, 0, 1, 1, 1, 0, TNEW_LD,  0, FWD_M,  FWD_RF);
        vecs[9]  = mk(1, 0,  1, TUSE_BR,  0, 1, 0, 0, 0, 0,        0, FWD_RF, FWD_RF);
        vecs[10] = mk(1, 1,  1, TUSE_BR,  2, 1, 0, 0, 0, 0,        0, FWD_RF, FWD_RF);
        vecs[11] = mk(1, 0,  1, TUSE_ALU, 0, 0, 0, 1, 4, TNEW_ALU, 0, FWD_RF, FWD_RF);
        vecs[12] = mk(1, 4,  1, TUSE_ALU, 3, 1, 1, 1, 4, TNEW_ALU, 0, FWD_E,  FWD_RF);
        vecs[13] = mk(1, 4,  1, TUSE_BR,  0, 0, 0, 0, 0, 0,        1, FWD_E,  FWD_RF);
        vecs[14] = mk(1, 4,  1, TUSE_BR,  0, 0, 0, 0, 0, 0,        0, FWD_M,  FWD_RF);
        vecs[15] = mk(1, 4,  0, TUSE_BR,  0, 0, 0, 0, 0, 0,        0, FWD_W,  FWD_RF);
        vecs[16] = mk(1, 4,  1, TUSE_BR,  0, 0, 0, 0, 0, 0,        0, FWD_RF, FWD_RF);
        vecs[17] = mk(1, 29, 1, TUSE_ALU, 0, 0, 0, 1, 8, TNEW_LD,  0, FWD_RF, FWD_RF);
        vecs[18] = mk(0, 8,  1, TUSE_BR,  0, 0, 0, 0, 0, 0,        0, FWD_E,  FWD_RF);
        vecs[19] = mk(1, 8,  1, TUSE_BR,  0, 0, 0, 0, 0, 0,        1, FWD_M,  FWD_RF);
        vecs[20] = mk(1, 8,  1, TUSE_BR,  0, 0, 0, 0, 0, 0,        0, FWD_W,  FWD_RF);

        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk("reset_state", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 chk($sformatf("row%0d", i), vecs[i].e_stall, vecs[i].e_rs, vecs[i].e_rt, 1'b0);
        end

        // div then mflo: interlock held for the full divide latency
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
        #1 chk("div_issue", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, TNEW_ALU, 0, 0, 0));
            d_md_use = 1'b1;
            #1 chk($sformatf("mflo_wait%0d", i), MD, 0, 0, MD);
        end
        @(negedge clk);
        #1 chk("mflo_go", 0, 0, 0, 0);

        // mult then mfhi: shorter latency
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        d_md_start = 1'b1; d_md_use = 1'b1;
        #1 chk("mult_issue", 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            d_md_use = 1'b1;
            #1 chk($sformatf("mfhi_wait%0d", i), MD, 0, 0, MD);
        end
        @(negedge clk);
        #1 chk("mfhi_go", 0, 0, 0, 0);

        // async reset mid-divide with a pending load
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
        #1 chk("rst_div_issue", 0, 0, 0, 0);
        @(negedge clk);
        drive(mk(1, 29, 1, TUSE_ALU, 0, 0, 0, 1, 10, TNEW_LD, 0, 0, 0));
        #1 chk("rst_lw_issue", 0, 0, 0, MD);
        @(negedge clk);
        drive(mk(1, 10, 1, TUSE_BR, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        d_md_use = 1'b1;
        #1 chk("rst_before", 1, FWD_E, FWD_RF, MD);
        #2 reset = 1'b1;
        #1 chk("rst_async", 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1 chk("rst_release", 0, 0, 0, 0);
        d_valid = 1'b0;
        @(negedge clk);
        #1 chk("rst_empty", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
